// File: rtl/conv_stream_if.sv
// Output stream of conv_stream_engine: signed result plus channel/position tags,
// valid/ready handshake.
interface conv_stream_if #(
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned CHAN_W = 4,
    parameter int unsigned ROW_W  = 4,
    parameter int unsigned COL_W  = 4
);
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CHAN_W-1:0]        out_chan;
    logic [ROW_W-1:0]         out_row;
    logic [COL_W-1:0]         out_col;
    logic                     out_eoc;
    logic                     out_last;

    modport master (
        output out_data, out_valid, out_chan, out_row, out_col, out_eoc, out_last,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_chan, out_row, out_col, out_eoc, out_last,
        output out_ready
    );
endinterface

// File: rtl/conv_stream_engine.sv
// Streaming multi-channel 2-D convolution: one start pulse sweeps every channel/row/column
// through a 2-stage window/MAC pipeline. Define CONV_STREAM_RELU_EN to clamp negative sums to 0.
module conv_stream_engine #(
    parameter int unsigned IN_H   = 16,
    parameter int unsigned IN_W   = 15,
    parameter int unsigned K_H    = 3,
    parameter int unsigned K_W    = 3,
    parameter int unsigned CHAN   = 10,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned ACC_W  = 24
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [IN_H*IN_W*8-1:0]      in_img,
    input  logic [K_H*K_W*CHAN*8-1:0]   w_conv,
    output logic                        busy,
    output logic                        done,
    conv_stream_if.master               strm
);
    localparam int unsigned OUT_H = (IN_H - K_H) / STRIDE + 1;
    localparam int unsigned OUT_W = (IN_W - K_W) / STRIDE + 1;
    localparam int unsigned NPIX  = OUT_H * OUT_W;
    localparam int unsigned NWIN  = K_H * K_W;
    localparam int unsigned CW    = (CHAN  > 1) ? $clog2(CHAN)  : 1;
    localparam int unsigned RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int unsigned CLW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [CW-1:0]  LAST_CHAN = CW'(CHAN - 1);
    localparam logic [RW-1:0]  LAST_ROW  = RW'(OUT_H - 1);
    localparam logic [CLW-1:0] LAST_COL  = CLW'(OUT_W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]  chan_q;
    logic [RW-1:0]  row_q;
    logic [CLW-1:0] col_q;

    // Stage 1: captured window, weights and tags
    logic           s1_valid_q;
    logic [7:0]     win_q [NWIN];
    logic [7:0]     wgt_q [NWIN];
    logic [CW-1:0]  s1_chan_q;
    logic [RW-1:0]  s1_row_q;
    logic [CLW-1:0] s1_col_q;
    logic           s1_eoc_q;
    logic           s1_last_q;

    // Stage 2: registered result driving the stream
    logic                    s2_valid_q;
    logic signed [ACC_W-1:0] s2_data_q;
    logic [CW-1:0]           s2_chan_q;
    logic [RW-1:0]           s2_row_q;
    logic [CLW-1:0]          s2_col_q;
    logic                    s2_eoc_q;
    logic                    s2_last_q;

    logic [7:0] win_d [NWIN];
    logic [7:0] wgt_d [NWIN];
    logic       stall;
    logic       issue;
    logic       eoc_now;
    logic       final_win;
    logic       accept;

    logic signed [16:0]      pix_s;
    logic signed [16:0]      wgt_s;
    logic signed [16:0]      prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum_out;
    int                      pix_idx;

    assign stall     = s2_valid_q & ~strm.out_ready;
    assign issue     = (state_q == StRun) & ~stall;
    assign eoc_now   = (row_q == LAST_ROW) & (col_q == LAST_COL);
    assign final_win = eoc_now & (chan_q == LAST_CHAN);
    assign accept    = (state_q == StIdle) & start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                busy = 1'b1;
                if (issue && final_win) state_d = StDrain;
            end
            StDrain: begin
                busy = 1'b1;
                if (s2_valid_q && strm.out_ready && s2_last_q) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Window origin is (row*STRIDE, col*STRIDE); weights follow the current channel.
    always_comb begin
        pix_idx = 0;
        for (int k = 0; k < NWIN; k++) begin
            win_d[k] = '0;
            wgt_d[k] = '0;
        end
        for (int i = 0; i < K_H; i++) begin
            for (int j = 0; j < K_W; j++) begin
                pix_idx = (int'(row_q) * STRIDE + i) * IN_W + int'(col_q) * STRIDE + j;
                win_d[i*K_W+j] = in_img[pix_idx*8 +: 8];
                wgt_d[i*K_W+j] = w_conv[((int'(chan_q) * K_H + i) * K_W + j) * 8 +: 8];
            end
        end
    end

    // Pixels are unsigned, so they are zero-extended before the signed multiply.
    always_comb begin
        acc   = '0;
        pix_s = '0;
        wgt_s = '0;
        prod  = '0;
        for (int k = 0; k < NWIN; k++) begin
            pix_s = {9'b0, win_q[k]};
            wgt_s = {{9{wgt_q[k][7]}}, wgt_q[k]};
            prod  = pix_s * wgt_s;
            acc   = acc + {{(ACC_W-17){prod[16]}}, prod};
        end
    end

    always_comb begin
`ifdef CONV_STREAM_RELU_EN
        sum_out = acc[ACC_W-1] ? '0 : acc;
`else
        sum_out = acc;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else if (accept) begin
            chan_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else if (issue) begin
            if (col_q == LAST_COL) begin
                col_q <= '0;
                if (row_q == LAST_ROW) begin
                    row_q  <= '0;
                    chan_q <= (chan_q == LAST_CHAN) ? '0 : chan_q + 1'b1;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            for (int k = 0; k < NWIN; k++) begin
                win_q[k] <= '0;
                wgt_q[k] <= '0;
            end
            s1_chan_q <= '0;
            s1_row_q  <= '0;
            s1_col_q  <= '0;
            s1_eoc_q  <= 1'b0;
            s1_last_q <= 1'b0;
        end else if (!stall) begin
            s1_valid_q <= issue;
            if (issue) begin
                for (int k = 0; k < NWIN; k++) begin
                    win_q[k] <= win_d[k];
                    wgt_q[k] <= wgt_d[k];
                end
                s1_chan_q <= chan_q;
                s1_row_q  <= row_q;
                s1_col_q  <= col_q;
                s1_eoc_q  <= eoc_now;
                s1_last_q <= final_win;
            end
        end
    end

    // S2 holds data and tags while the downstream stalls a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_chan_q  <= '0;
            s2_row_q   <= '0;
            s2_col_q   <= '0;
            s2_eoc_q   <= 1'b0;
            s2_last_q  <= 1'b0;
        end else if (!stall) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= sum_out;
                s2_chan_q <= s1_chan_q;
                s2_row_q  <= s1_row_q;
                s2_col_q  <= s1_col_q;
                s2_eoc_q  <= s1_eoc_q;
                s2_last_q <= s1_last_q;
            end
        end
    end

    assign strm.out_data  = s2_data_q;
    assign strm.out_valid = s2_valid_q;
    assign strm.out_chan  = s2_chan_q;
    assign strm.out_row   = s2_row_q;
    assign strm.out_col   = s2_col_q;
    assign strm.out_eoc   = s2_eoc_q;
    assign strm.out_last  = s2_last_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Randomised bench for conv_stream_engine: stride-1 and stride-2 instances checked against
// a direct convolution model, with backpressure, latency, done timing and mid-run reset.
module tb_conv_stream_engine;
    localparam int IN_H = 16;
    localparam int IN_W = 15;
    localparam int K_H  = 3;
    localparam int K_W  = 3;
    localparam int CHAN = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic ready;
    int   sel;
    logic [IN_H*IN_W*8-1:0]    in_img;
    logic [K_H*K_W*CHAN*8-1:0] w_conv;
    logic busy_a, done_a, busy_b, done_b;

    int img [IN_H][IN_W];
    int wt  [CHAN][K_H][K_W];
    int n_checks = 0;
    int n_pass   = 0;

    conv_stream_if #(.ACC_W(24), .CHAN_W(4), .ROW_W(4), .COL_W(4)) ifa ();
    conv_stream_if #(.ACC_W(24), .CHAN_W(4), .ROW_W(3), .COL_W(3)) ifb ();

    assign ifa.out_ready = ready;
    assign ifb.out_ready = ready;

    conv_stream_engine dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start && (sel == 0)),
        .in_img (in_img),
        .w_conv (w_conv),
        .busy   (busy_a),
        .done   (done_a),
        .strm   (ifa)
    );

    conv_stream_engine #(.STRIDE(2)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start && (sel == 1)),
        .in_img (in_img),
        .w_conv (w_conv),
        .busy   (busy_b),
        .done   (done_b),
        .strm   (ifb)
    );

    always #5 clk = ~clk;

    logic              mon_valid, mon_eoc, mon_last, mon_busy, mon_done;
    logic signed [23:0] mon_data;
    int                mon_chan, mon_row, mon_col;

    always_comb begin
        if (sel == 1) begin
            mon_valid = ifb.out_valid;
            mon_data  = ifb.out_data;
            mon_chan  = int'(ifb.out_chan);
            mon_row   = int'(ifb.out_row);
            mon_col   = int'(ifb.out_col);
            mon_eoc   = ifb.out_eoc;
            mon_last  = ifb.out_last;
            mon_busy  = busy_b;
            mon_done  = done_b;
        end else begin
            mon_valid = ifa.out_valid;
            mon_data  = ifa.out_data;
            mon_chan  = int'(ifa.out_chan);
            mon_row   = int'(ifa.out_row);
            mon_col   = int'(ifa.out_col);
            mon_eoc   = ifa.out_eoc;
            mon_last  = ifa.out_last;
            mon_busy  = busy_a;
            mon_done  = done_a;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pack_tags(int ch, int r, int c, int eoc, int last);
        return ch * 4096 + r * 64 + c * 4 + eoc * 2 + last;
    endfunction

    function automatic int mon_tags();
        return pack_tags(mon_chan, mon_row, mon_col, int'(mon_eoc), int'(mon_last));
    endfunction

    // Direct convolution at output (r,c) of channel ch.
    function automatic int ref_val(int stride, int ch, int r, int c);
        int s = 0;
        for (int i = 0; i < K_H; i++)
            for (int j = 0; j < K_W; j++)
                s += img[r*stride+i][c*stride+j] * wt[ch][i][j];
`ifdef CONV_STREAM_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic set_data(input int mode);
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++) begin
                case (mode)
                    0:       img[r][c] = 1;
                    1:       img[r][c] = 255;
                    2:       img[r][c] = r * IN_W + c;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
                in_img[(r*IN_W+c)*8 +: 8] = 8'(img[r][c]);
            end
        for (int ch = 0; ch < CHAN; ch++)
            for (int i = 0; i < K_H; i++)
                for (int j = 0; j < K_W; j++) begin
                    case (mode)
                        0:       wt[ch][i][j] = ch - 5;
                        1:       wt[ch][i][j] = -128;
                        2:       wt[ch][i][j] = (i == 1 && j == 1) ? 1 : 0;
                        default: wt[ch][i][j] = int'($urandom_range(0, 255)) - 128;
                    endcase
                    w_conv[((ch*K_H+i)*K_W+j)*8 +: 8] = 8'(wt[ch][i][j]);
                end
    endtask

    task automatic run(input int s, input int rdy_mode, input int abort_k);
        int  stride, oh, ow, npix, total, k, cyc, budget, stall_cnt, ch, pix, exp_tags;
        int  sv_data, sv_tags;
        bit  got_first, prev_stall, finished, forced;
        sel       = s;
        stride    = (s == 1) ? 2 : 1;
        oh        = (IN_H - K_H) / stride + 1;
        ow        = (IN_W - K_W) / stride + 1;
        npix      = oh * ow;
        total     = CHAN * npix;
        budget    = 4 * total + 50;
        k         = 0;
        cyc       = 0;
        stall_cnt = 0;
        got_first = 0;
        prev_stall = 0;
        finished  = 0;
        forced    = 0;
        sv_data   = 0;
        sv_tags   = 0;
        ready     = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(mon_busy), 1);
        while (cyc < budget) begin
            if (prev_stall) begin
                check("stall_valid", int'(mon_valid), 1);
                check("stall_data", int'(mon_data), sv_data);
                check("stall_tags", mon_tags(), sv_tags);
            end
            if (k == total) begin
                check("done_pulse", int'(mon_done), 1);
                check("busy_at_done", int'(mon_busy), 0);
                check("valid_at_done", int'(mon_valid), 0);
                if (rdy_mode == 0) check("run_length", cyc, total + 2);
                finished = 1;
                break;
            end
            check("done_early", int'(mon_done), 0);
            if (mon_valid && !got_first) begin
                check("first_latency", cyc, 2);
                got_first = 1;
            end
            if (abort_k >= 0 && k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid", int'(mon_valid), 0);
                check("rst_data", int'(mon_data), 0);
                check("rst_tags", mon_tags(), 0);
                check("rst_busy", int'(mon_busy), 0);
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", int'(mon_done), 0);
                end
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("post_rst_done", int'(mon_done), 0);
                    check("post_rst_busy", int'(mon_busy), 0);
                end
                return;
            end
            if (rdy_mode == 0) begin
                ready = 1'b1;
            end else begin
                if (!forced && k == total / 3 + 7) begin
                    forced    = 1;
                    stall_cnt = 10;
                end
                if (stall_cnt > 0) begin
                    ready = 1'b0;
                    stall_cnt--;
                end else begin
                    ready = ($urandom_range(0, 3) != 0);
                end
            end
            if (mon_valid && ready) begin
                ch  = k / npix;
                pix = k % npix;
                exp_tags = pack_tags(ch, pix / ow, pix % ow, int'(pix == npix - 1),
                                     int'(k == total - 1));
                check("data", int'(mon_data), ref_val(stride, ch, pix / ow, pix % ow));
                check("tags", mon_tags(), exp_tags);
                k++;
            end
            prev_stall = mon_valid && !ready;
            sv_data    = int'(mon_data);
            sv_tags    = mon_tags();
            @(negedge clk);
            cyc++;
        end
        check("run_complete", int'(finished), 1);
        check("handshakes", k, total);
        ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        sel   = 0;
        set_data(0);
        #1;
        check("reset_valid_a", int'(ifa.out_valid), 0);
        check("reset_data_a", int'(ifa.out_data), 0);
        check("reset_busy_a", int'(busy_a), 0);
        check("reset_done_a", int'(done_a), 0);
        check("reset_valid_b", int'(ifb.out_valid), 0);
        check("reset_busy_b", int'(busy_b), 0);
        check("reset_tags_a", pack_tags(int'(ifa.out_chan), int'(ifa.out_row),
              int'(ifa.out_col), int'(ifa.out_eoc), int'(ifa.out_last)), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 0, -1);          // ones / c-5 weights
        set_data(1);
        run(0, 0, -1);          // full-scale negative
        set_data(2);
        run(0, 0, -1);          // ramp with centre tap
        set_data(3);
        run(0, 1, -1);          // random data, random backpressure
        set_data(3);
        run(1, 1, -1);          // stride 2, backpressure
        run(1, 0, -1);          // stride 2, full throughput
        set_data(0);
        run(0, 0, 4 * 182 + 90);  // reset in channel 4
        run(0, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
